// File: rtl/calc_pkg.sv
// Shared definitions for the command-issue front end of the accumulator.
// Holds the opcode map, the issue FSM state type, the indices of the
// accumulator error flags and the rule that decides when an error flag
// counts as a fault for the command currently on the issue bus.
package calc_pkg;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] GND = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0011;
    localparam logic [3:0] MUL = 4'b0100;
    localparam logic [3:0] DIV = 4'b0101;
    localparam logic [3:0] MOD = 4'b0110;
    localparam logic [3:0] RST = 4'b1111;

    // Bit positions inside the accumulator ERR bus
    localparam int ERR_OVF  = 0;   // overflow
    localparam int ERR_DIVZ = 1;   // divide / modulo by zero

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HLT   = 2'd2
    } state_e;

    // An error flag only matters for the opcodes that can raise it:
    // overflow for ADD/SUB, divide-by-zero for DIV/MOD.
    function automatic logic is_fault(input logic [3:0] op, input logic [1:0] err);
        logic ovf_op;
        logic div_op;
        ovf_op = (op == ADD) || (op == SUB);
        div_op = (op == DIV) || (op == MOD);
        return (err[ERR_OVF] && ovf_op) || (err[ERR_DIVZ] && div_op);
    endfunction

endpackage

// File: rtl/cmd_issue_if.sv
// Bundle of the producer handshake, the issue bus to the accumulator and
// the fault/status lines of cmd_issue.
//   master : producer / accumulator side (drives command, ERR, CLR)
//   slave  : cmd_issue side (drives READY, issue bus, HALT, ERR_OP, COUNT)
interface cmd_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          CMD_VALID;
    logic          CMD_READY;
    logic [3:0]    CMD_OP;
    logic [15:0]   CMD_IN1;
    logic [3:0]    ISS_OP;
    logic [15:0]   ISS_IN1;
    logic [1:0]    ERR;
    logic          CLR;
    logic          HALT;
    logic [3:0]    ERR_OP;
    logic [CW-1:0] COUNT;

    modport master (
        output CMD_VALID, CMD_OP, CMD_IN1, ERR, CLR,
        input  CMD_READY, ISS_OP, ISS_IN1, HALT, ERR_OP, COUNT
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_IN1, ERR, CLR,
        output CMD_READY, ISS_OP, ISS_IN1, HALT, ERR_OP, COUNT
    );
endinterface

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH entries of {opcode, operand} (20 bits).
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset (empties the queue)
//   push_i      write wdata_i (ignored when full)
//   wdata_i     entry to write
//   pop_i       drop the head entry (ignored when empty)
//   rdata_o     current head entry (valid when count_o != 0)
//   count_o     occupancy 0..DEPTH
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push_i,
    input  logic [19:0]              wdata_i,
    input  logic                     pop_i,
    output logic [19:0]              rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push_i && (count_q < FULL);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cmd_issue.sv
// Command issue stage: queues commands from a producer and hands them one
// per cycle to the accumulator datapath. A fault reported by the
// accumulator for the command just issued stops issue (HALT) until CLR.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         cmd_issue_if.slave: CMD_VALID/READY/OP/IN1 in,
//               ISS_OP/ISS_IN1 out, ERR/CLR in, HALT/ERR_OP/COUNT out
module cmd_issue
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RST_N,
    cmd_issue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [3:0]    iss_op_q, iss_op_d;
    logic [15:0]   iss_in1_q, iss_in1_d;
    logic          halt_q, halt_d;
    logic [3:0]    err_op_q, err_op_d;

    logic [CW-1:0] count;
    logic [19:0]   head;
    logic          ready, push, pop, fault;

    // Ready depends only on occupancy, so a full queue refuses a push even
    // in a cycle where the head is being popped.
    assign ready = (count < CW'(DEPTH));
    assign push  = bus.CMD_VALID && ready;

    // Only the cycle in which a real command sat on the issue bus can fault.
    assign fault = (state_q == ISSUE) && is_fault(iss_op_q, bus.ERR);

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (push),
        .wdata_i ({bus.CMD_OP, bus.CMD_IN1}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        iss_op_d  = iss_op_q;
        iss_in1_d = iss_in1_q;
        halt_d    = halt_q;
        err_op_d  = err_op_q;
        pop       = 1'b0;
        case (state_q)
            IDLE, ISSUE: begin
                if (fault) begin
                    // Faulting command is not retried; the next queued one
                    // stays at the head until CLR.
                    iss_op_d  = NOP;
                    iss_in1_d = '0;
                    err_op_d  = iss_op_q;
                    halt_d    = 1'b1;
                    state_d   = HLT;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    iss_op_d  = head[19:16];
                    iss_in1_d = head[15:0];
                    state_d   = ISSUE;
                end else begin
                    iss_op_d  = NOP;
                    iss_in1_d = '0;
                    state_d   = IDLE;
                end
            end
            HLT: begin
                iss_op_d  = NOP;
                iss_in1_d = '0;
                if (bus.CLR) begin
                    halt_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                iss_op_d  = NOP;
                iss_in1_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            iss_op_q  <= NOP;
            iss_in1_q <= '0;
            halt_q    <= 1'b0;
            err_op_q  <= NOP;
        end else begin
            state_q   <= state_d;
            iss_op_q  <= iss_op_d;
            iss_in1_q <= iss_in1_d;
            halt_q    <= halt_d;
            err_op_q  <= err_op_d;
        end
    end

    assign bus.CMD_READY = ready;
    assign bus.ISS_OP    = iss_op_q;
    assign bus.ISS_IN1   = iss_in1_q;
    assign bus.HALT      = halt_q;
    assign bus.ERR_OP    = err_op_q;
    assign bus.COUNT     = count;

endmodule

// File: tb/tb_cmd_issue.sv
// Self-checking bench for cmd_issue: a directed vector table, hand-written
// halt/reset sequences, and a randomized run against a queue-based model.
module tb_cmd_issue;
    import calc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmd_issue_if #(.DEPTH(DEPTH)) bus();

    cmd_issue #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] in1,
                         input logic [1:0] err, input logic clr);
        bus.CMD_VALID = v;
        bus.CMD_OP    = op;
        bus.CMD_IN1   = in1;
        bus.ERR       = err;
        bus.CLR       = clr;
    endtask

    task automatic idle_in();
        drive(1'b0, NOP, 16'd0, 2'b00, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ready, input logic [3:0] op,
                             input logic [15:0] in1, input logic halt,
                             input logic [3:0] errop, input logic [2:0] cnt);
        chk({tag, ".ready"}, 32'(bus.CMD_READY), 32'(ready));
        chk({tag, ".iss_op"}, 32'(bus.ISS_OP), 32'(op));
        chk({tag, ".iss_in1"}, 32'(bus.ISS_IN1), 32'(in1));
        chk({tag, ".halt"}, 32'(bus.HALT), 32'(halt));
        chk({tag, ".err_op"}, 32'(bus.ERR_OP), 32'(errop));
        chk({tag, ".count"}, 32'(bus.COUNT), 32'(cnt));
    endtask

    task automatic do_reset();
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        step();
        #2 rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] in1;
        logic [1:0]  err;
        logic        clr;
        logic        e_ready;
        logic [3:0]  e_op;
        logic [15:0] e_in1;
        logic        e_halt;
        logic [3:0]  e_errop;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[18];

    // ---------------- behavioural reference model ----------------
    // The model keeps the waiting commands in a queue and the command on
    // the issue bus; a fault is decided directly from the opcode/flag rule.
    logic [19:0] mq[$];
    logic [3:0]  m_op;
    logic [15:0] m_in1;
    logic        m_in1_care;
    logic        m_halt;
    logic [3:0]  m_errop;

    function automatic void model_reset();
        mq.delete();
        m_op = NOP; m_in1 = 16'd0; m_in1_care = 1'b1;
        m_halt = 1'b0; m_errop = NOP;
    endfunction

    function automatic void model_edge(input logic v, input logic [3:0] op, input logic [15:0] in1,
                                       input logic [1:0] err, input logic clr);
        bit acc;
        bit flt;
        acc = v && (mq.size() < DEPTH);
        flt = !m_halt && ((err[0] && (m_op == ADD || m_op == SUB)) ||
                          (err[1] && (m_op == DIV || m_op == MOD)));
        if (m_halt) begin
            m_op = NOP; m_in1_care = 1'b0;
            if (clr) m_halt = 1'b0;
        end else if (flt) begin
            m_errop = m_op; m_halt = 1'b1; m_op = NOP; m_in1_care = 1'b0;
        end else if (mq.size() > 0) begin
            {m_op, m_in1} = mq.pop_front();
            m_in1_care = 1'b1;
        end else begin
            m_op = NOP; m_in1 = 16'd0; m_in1_care = 1'b1;
        end
        if (acc) mq.push_back({op, in1});
    endfunction

    logic [3:0] op_pool[8];

    initial begin
        op_pool[0] = NOP; op_pool[1] = GND; op_pool[2] = ADD; op_pool[3] = SUB;
        op_pool[4] = MUL; op_pool[5] = DIV; op_pool[6] = MOD; op_pool[7] = RST;

        //           v  op   in1  err  clr  rdy op   in1 halt errop cnt
        tbl[0]  = '{1, ADD, 11, 2'b00, 0,  1, NOP, 0,  0, NOP, 1};
        tbl[1]  = '{1, ADD, 15, 2'b00, 0,  1, ADD, 11, 0, NOP, 1};
        tbl[2]  = '{0, NOP, 0,  2'b00, 0,  1, ADD, 15, 0, NOP, 0};
        tbl[3]  = '{0, NOP, 0,  2'b00, 0,  1, NOP, 0,  0, NOP, 0};
        tbl[4]  = '{1, DIV, 5,  2'b00, 0,  1, NOP, 0,  0, NOP, 1};
        tbl[5]  = '{1, ADD, 3,  2'b00, 0,  1, DIV, 5,  0, NOP, 1};
        tbl[6]  = '{0, NOP, 0,  2'b10, 0,  1, NOP, 0,  1, DIV, 1};
        tbl[7]  = '{0, NOP, 0,  2'b00, 1,  1, NOP, 0,  0, DIV, 1};
        tbl[8]  = '{0, NOP, 0,  2'b00, 0,  1, ADD, 3,  0, DIV, 0};
        tbl[9]  = '{0, NOP, 0,  2'b00, 0,  1, NOP, 0,  0, DIV, 0};
        tbl[10] = '{1, ADD, 7,  2'b00, 0,  1, NOP, 0,  0, DIV, 1};
        tbl[11] = '{1, SUB, 9,  2'b10, 0,  1, ADD, 7,  0, DIV, 1};
        tbl[12] = '{0, NOP, 0,  2'b10, 0,  1, SUB, 9,  0, DIV, 0};
        tbl[13] = '{0, NOP, 0,  2'b00, 0,  1, NOP, 0,  0, DIV, 0};
        tbl[14] = '{1, MUL, 2,  2'b11, 0,  1, NOP, 0,  0, DIV, 1};
        tbl[15] = '{1, RST, 4,  2'b11, 0,  1, MUL, 2,  0, DIV, 1};
        tbl[16] = '{0, NOP, 0,  2'b11, 0,  1, RST, 4,  0, DIV, 0};
        tbl[17] = '{0, NOP, 0,  2'b11, 1,  1, NOP, 0,  0, DIV, 0};

        // ---- reset state ----
        rst_n = 1'b0;
        idle_in();
        step();
        step();
        check_all("reset", 1'b1, NOP, 16'd0, 1'b0, NOP, 3'd0);
        #2 rst_n = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].in1, tbl[i].err, tbl[i].clr);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_op, tbl[i].e_in1,
                      tbl[i].e_halt, tbl[i].e_errop, tbl[i].e_cnt);
            $display("vec %0d: op=%0h in1=%0d halt=%0b cnt=%0d", i, bus.ISS_OP, bus.ISS_IN1,
                     bus.HALT, bus.COUNT);
        end
        idle_in();

        // ---- halt, queue 3, asynchronous reset mid-cycle ----
        drive(1'b1, SUB, 16'd1, 2'b00, 1'b0); step();
        drive(1'b1, GND, 16'd2, 2'b00, 1'b0); step();        // SUB on bus
        chk("seqA.sub_issued", 32'(bus.ISS_OP), 32'(SUB));
        drive(1'b1, GND, 16'd3, 2'b01, 1'b0); step();        // overflow on SUB
        chk("seqA.halt", 32'(bus.HALT), 32'd1);
        chk("seqA.err_op", 32'(bus.ERR_OP), 32'(SUB));
        drive(1'b1, GND, 16'd4, 2'b00, 1'b0); step();
        idle_in();
        chk("seqA.count3", 32'(bus.COUNT), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_all("seqA.async_rst", 1'b1, NOP, 16'd0, 1'b0, NOP, 3'd0);
        $display("seqA: reset asserted between edges, count=%0d", bus.COUNT);
        #1 rst_n = 1'b1;
        drive(1'b1, ADD, 16'd21, 2'b00, 1'b0); step();
        idle_in();
        chk("seqA.post_push_nop", 32'(bus.ISS_OP), 32'(NOP));
        chk("seqA.post_push_cnt", 32'(bus.COUNT), 32'd1);
        step();
        chk("seqA.post_issue_op", 32'(bus.ISS_OP), 32'(ADD));
        chk("seqA.post_issue_in1", 32'(bus.ISS_IN1), 32'd21);
        step();

        // ---- halted queue fills to DEPTH, fifth push refused ----
        drive(1'b1, ADD, 16'd1, 2'b00, 1'b0); step();
        idle_in(); step();
        drive(1'b0, NOP, 16'd0, 2'b01, 1'b0); step();
        idle_in();
        chk("seqB.halt", 32'(bus.HALT), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, GND, 16'(100 + i), 2'b00, 1'b0);
            #1;
            chk($sformatf("seqB.ready%0d", i), 32'(bus.CMD_READY), (i < 4) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("seqB.count%0d", i), 32'(bus.COUNT), (i < 4) ? 32'(i + 1) : 32'd4);
            $display("seqB push %0d: ready=%0b count=%0d", i, bus.CMD_READY, bus.COUNT);
        end
        idle_in();
        chk("seqB.iss_nop", 32'(bus.ISS_OP), 32'(NOP));
        // CLR releases; queued GND/100 is first out
        drive(1'b0, NOP, 16'd0, 2'b00, 1'b1); step();
        idle_in(); step();
        chk("seqB.drain_op", 32'(bus.ISS_OP), 32'(GND));
        chk("seqB.drain_in1", 32'(bus.ISS_IN1), 32'd100);

        // ---- randomized run against the model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic        v;
            logic [3:0]  op;
            logic [15:0] in1;
            logic [1:0]  err;
            logic        clr;
            v   = ($urandom_range(0, 99) < 60);
            op  = op_pool[$urandom_range(0, 7)];
            in1 = 16'($urandom);
            err = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'b00;
            clr = ($urandom_range(0, 99) < 15);
            drive(v, op, in1, err, clr);
            #1;
            chk($sformatf("rnd%0d.ready", c), 32'(bus.CMD_READY),
                32'(mq.size() < DEPTH));
            @(posedge clk);
            model_edge(v, op, in1, err, clr);
            #1;
            chk($sformatf("rnd%0d.op", c), 32'(bus.ISS_OP), 32'(m_op));
            if (m_in1_care)
                chk($sformatf("rnd%0d.in1", c), 32'(bus.ISS_IN1), 32'(m_in1));
            chk($sformatf("rnd%0d.halt", c), 32'(bus.HALT), 32'(m_halt));
            chk($sformatf("rnd%0d.errop", c), 32'(bus.ERR_OP), 32'(m_errop));
            chk($sformatf("rnd%0d.count", c), 32'(bus.COUNT), 32'(mq.size()));
            $display("rnd %0d: v=%0b op=%0h err=%0b clr=%0b -> iss=%0h halt=%0b cnt=%0d",
                     c, v, op, err, clr, bus.ISS_OP, bus.HALT, bus.COUNT);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
